// File: rtl/ysyx_axi_pkg.sv
// Shared AXI4 codes and FSM state types
// for the on-chip SRAM responder.
package ysyx_axi_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   typedef enum logic [1:0] {
      R_IDLE,
      R_WAIT,
      R_DATA
   } rstate_t;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_WAIT,
      W_RESP
   } wstate_t;

   // Byte step between beats; WRAP is served as INCR
   function automatic logic [7:0] beat_step(
      input logic [1:0] burst,
      input logic [2:0] size
   );
      return (burst == BURST_FIXED) ? 8'd0 : (8'd1 << size);
   endfunction

   // DECERR outranks SLVERR
   function automatic logic [1:0] resp_of(
      input logic dec,
      input logic slv
   );
      if (dec) return RESP_DECERR;
      if (slv) return RESP_SLVERR;
      return RESP_OKAY;
   endfunction

endpackage

// File: rtl/ysyx_sram_bank64.sv
// DEPTH x 64 storage: byte-enable synchronous
// write port, asynchronous read port.
module ysyx_sram_bank64 #(
   parameter int DEPTH = 4096,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [7:0]    wstrb,
   input  logic [AW-1:0] waddr,
   input  logic [63:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [63:0]   rdata
);

   logic [63:0] mem [DEPTH];

   // Commit the enabled byte lanes of a write beat
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 8; i++) begin
            if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/ysyx_axi4_sram.sv
// AXI4 responder over a 64-bit on-chip SRAM with
// independent read and write channel FSMs.
module ysyx_axi4_sram
   import ysyx_axi_pkg::*;
#(
   parameter int                ADDR_W = 32,
   parameter logic [ADDR_W-1:0] BASE   = 'h8000_0000,
   parameter int                DEPTH  = 4096,
   parameter int                RD_LAT = 1,
   parameter int                WR_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        arburst,
   input  logic [2:0]        arsize,
   input  logic [7:0]        arlen,
   input  logic [3:0]        arid,
   input  logic [ADDR_W-1:0] araddr,
   input  logic              arvalid,
   output logic              arready_o,
   output logic [3:0]        rid_o,
   output logic              rlast_o,
   output logic [63:0]       rdata_o,
   output logic [1:0]        rresp_o,
   output logic              rvalid_o,
   input  logic              rready,
   input  logic [1:0]        awburst,
   input  logic [2:0]        awsize,
   input  logic [7:0]        awlen,
   input  logic [3:0]        awid,
   input  logic [ADDR_W-1:0] awaddr,
   input  logic              awvalid,
   output logic              awready_o,
   input  logic [63:0]       wdata,
   input  logic [7:0]        wstrb,
   input  logic              wlast,
   input  logic              wvalid,
   output logic              wready_o,
   output logic [3:0]        bid_o,
   output logic [1:0]        bresp_o,
   output logic              bvalid_o,
   input  logic              bready
);

   localparam int              AW   = $clog2(DEPTH);
   localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(8 * DEPTH);

   rstate_t           rstate;
   wstate_t           wstate;
   logic [ADDR_W-1:0] raddr_q;
   logic [ADDR_W-1:0] waddr_q;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] rd_off;
   logic [ADDR_W-1:0] wr_off;
   logic [7:0]        rlen_q;
   logic [7:0]        rcnt;
   logic [7:0]        wlen_q;
   logic [7:0]        wcnt;
   logic [1:0]        rburst_q;
   logic [1:0]        wburst_q;
   logic [2:0]        rsize_q;
   logic [2:0]        wsize_q;
   logic [3:0]        rlat;
   logic [3:0]        wlat;
   logic              rd_inr;
   logic              wr_inr;
   logic [63:0]       mem_q;
   logic [63:0]       beat_data;
   logic [1:0]        beat_resp;
   logic              dec_err;
   logic              slv_err;
   logic              dec_nx;
   logic              slv_nx;
   logic              w_hs;
   logic              w_lenhit;
   logic              w_end;
   logic              unused_bits;

   assign arready_o = (rstate == R_IDLE) && !rst;
   assign awready_o = (wstate == W_IDLE) && !rst;

   // Address of the read beat about to be registered
   always_comb begin
      rd_addr = raddr_q;
      unique case (rstate)
         R_IDLE:  rd_addr = araddr;
         R_DATA:  rd_addr = raddr_q + ADDR_W'(beat_step(rburst_q, rsize_q));
         default: rd_addr = raddr_q;
      endcase
   end

   assign rd_off    = rd_addr - BASE;
   assign wr_off    = waddr_q - BASE;
   assign rd_inr    = {1'b0, rd_off} < SPAN;
   assign wr_inr    = {1'b0, wr_off} < SPAN;
   assign beat_data = rd_inr ? mem_q : 64'd0;
   assign beat_resp = rd_inr ? RESP_OKAY : RESP_DECERR;

   assign w_hs     = (wstate == W_DATA) && wvalid && wready_o;
   assign w_lenhit = (wcnt == wlen_q);
   assign w_end    = wlast || w_lenhit;
   assign dec_nx   = dec_err | (w_hs & ~wr_inr);
   assign slv_nx   = slv_err | (w_hs & (wlast != w_lenhit));

   assign unused_bits = ^{rd_off[2:0], wr_off[2:0]};

   ysyx_sram_bank64 #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_bank (
      .clk   (clk),
      .we    (w_hs && wr_inr),
      .wstrb (wstrb),
      .waddr (wr_off[AW+2:3]),
      .wdata (wdata),
      .raddr (rd_off[AW+2:3]),
      .rdata (mem_q)
   );

   // Read channel: latch AR, wait RD_LAT, stream beats
   always_ff @(posedge clk) begin
      if (rst) begin
         rstate   <= R_IDLE;
         raddr_q  <= '0;
         rlen_q   <= '0;
         rburst_q <= '0;
         rsize_q  <= '0;
         rcnt     <= '0;
         rlat     <= '0;
         rid_o    <= '0;
         rvalid_o <= 1'b0;
         rlast_o  <= 1'b0;
         rdata_o  <= '0;
         rresp_o  <= RESP_OKAY;
      end else begin
         unique case (rstate)
            R_IDLE: begin
               if (arvalid) begin
                  rid_o    <= arid;
                  raddr_q  <= araddr;
                  rlen_q   <= arlen;
                  rburst_q <= arburst;
                  rsize_q  <= arsize;
                  rcnt     <= '0;
                  rlat     <= 4'(RD_LAT);
                  if (RD_LAT == 0) begin
                     rstate   <= R_DATA;
                     rvalid_o <= 1'b1;
                     rdata_o  <= beat_data;
                     rresp_o  <= beat_resp;
                     rlast_o  <= (arlen == 8'd0);
                  end else begin
                     rstate <= R_WAIT;
                  end
               end
            end
            R_WAIT: begin
               rlat <= rlat - 4'd1;
               if (rlat <= 4'd1) begin
                  rstate   <= R_DATA;
                  rvalid_o <= 1'b1;
                  rdata_o  <= beat_data;
                  rresp_o  <= beat_resp;
                  rlast_o  <= (rlen_q == 8'd0);
               end
            end
            R_DATA: begin
               if (rready) begin
                  if (rlast_o) begin
                     rstate   <= R_IDLE;
                     rvalid_o <= 1'b0;
                     rlast_o  <= 1'b0;
                  end else begin
                     raddr_q <= rd_addr;
                     rcnt    <= rcnt + 8'd1;
                     rdata_o <= beat_data;
                     rresp_o <= beat_resp;
                     rlast_o <= ((rcnt + 8'd1) == rlen_q);
                  end
               end
            end
            default: rstate <= R_IDLE;
         endcase
      end
   end

   // Write channel: latch AW, absorb beats, wait WR_LAT, respond
   always_ff @(posedge clk) begin
      if (rst) begin
         wstate   <= W_IDLE;
         waddr_q  <= '0;
         wlen_q   <= '0;
         wburst_q <= '0;
         wsize_q  <= '0;
         wcnt     <= '0;
         wlat     <= '0;
         dec_err  <= 1'b0;
         slv_err  <= 1'b0;
         wready_o <= 1'b0;
         bid_o    <= '0;
         bvalid_o <= 1'b0;
         bresp_o  <= RESP_OKAY;
      end else begin
         unique case (wstate)
            W_IDLE: begin
               if (awvalid) begin
                  bid_o    <= awid;
                  waddr_q  <= awaddr;
                  wlen_q   <= awlen;
                  wburst_q <= awburst;
                  wsize_q  <= awsize;
                  wcnt     <= '0;
                  wready_o <= 1'b1;
                  wstate   <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_hs) begin
                  dec_err <= dec_nx;
                  slv_err <= slv_nx;
                  if (w_end) begin
                     wready_o <= 1'b0;
                     wlat     <= 4'(WR_LAT);
                     if (WR_LAT == 0) begin
                        wstate   <= W_RESP;
                        bvalid_o <= 1'b1;
                        bresp_o  <= resp_of(dec_nx, slv_nx);
                     end else begin
                        wstate <= W_WAIT;
                     end
                  end else begin
                     waddr_q <= waddr_q + ADDR_W'(beat_step(wburst_q, wsize_q));
                     wcnt    <= wcnt + 8'd1;
                  end
               end
            end
            W_WAIT: begin
               wlat <= wlat - 4'd1;
               if (wlat <= 4'd1) begin
                  wstate   <= W_RESP;
                  bvalid_o <= 1'b1;
                  bresp_o  <= resp_of(dec_err, slv_err);
               end
            end
            W_RESP: begin
               if (bready) begin
                  bvalid_o <= 1'b0;
                  dec_err  <= 1'b0;
                  slv_err  <= 1'b0;
                  wstate   <= W_IDLE;
               end
            end
            default: wstate <= W_IDLE;
         endcase
      end
   end

endmodule
